sand_sweep: RTL and testbench

SAND_SWEEP -- requirements
Module: sand_sweep

---
 rtl/sand_sweep.sv | 107 ++++++++++
 tb/tb_sand_sweep.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sand_sweep.sv
// sand_sweep: walks the pixel RAM bottom-up, feeding each word and the word below it to the sand update block and writing both results back.
// Ports: clk/reset (sync, active-high); start request, busy/done status; mem_* word-addressed RAM port with one-cycle read latency;
// upd_* control, region/floor operands and combinational results of the sand update block.
module sand_sweep #(
  parameter int WORDS_PER_ROW = 40,
  parameter int ROWS          = 480,
  parameter int ADDR_W        = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic              upd_docalc,
  output logic              upd_screenbegin,
  output logic              upd_screenend,
  output logic [31:0]       upd_region,
  output logic [31:0]       upd_floor,
  input  logic [31:0]       upd_new_region,
  input  logic [31:0]       upd_new_floor
);
  localparam int RW = $clog2(ROWS + 1);
  localparam int CW = $clog2(WORDS_PER_ROW + 1);
  typedef enum logic [2:0] {IDLE, RD_REG, RD_FLR, CAP, WR_REG, WR_FLR} state_t;
  state_t          state_q, state_d;
  logic [RW-1:0]   r_q, r_d;
  logic [CW-1:0]   c_q, c_d;
  logic            done_q, done_d;
  logic [31:0]     region_q, region_d, floor_q, floor_d;
  logic            c_last, last, rd_st, wr_st;
  logic [ADDR_W-1:0] reg_addr, flr_addr;
  always_comb begin
    c_last   = c_q == CW'(WORDS_PER_ROW - 1);
    last     = c_last && r_q == '0;
    state_d  = state_q;
    r_d      = r_q;
    c_d      = c_q;
    done_d   = 1'b0;
    region_d = region_q;
    floor_d  = floor_q;
    case (state_q)
      IDLE: begin
        // a start landing on the done cycle is dropped, not treated as a new request
        if (start && !done_q) begin
          state_d = RD_REG;
          r_d     = RW'(ROWS - 2);
          c_d     = '0;
        end
      end
      RD_REG: state_d = RD_FLR;
      RD_FLR: begin
        state_d  = CAP;
        region_d = mem_rdata;
      end
      CAP: begin
        state_d = WR_REG;
        floor_d = mem_rdata;
      end
      WR_REG: state_d = WR_FLR;
      WR_FLR: begin
        state_d = last ? IDLE : RD_REG;
        done_d  = last;
        c_d     = c_last ? '0 : c_q + CW'(1);
        r_d     = last ? '0 : c_last ? r_q - RW'(1) : r_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      r_q      <= '0;
      c_q      <= '0;
      done_q   <= 1'b0;
      region_q <= '0;
      floor_q  <= '0;
    end else begin
      state_q  <= state_d;
      r_q      <= r_d;
      c_q      <= c_d;
      done_q   <= done_d;
      region_q <= region_d;
      floor_q  <= floor_d;
    end
  end
  assign reg_addr = ADDR_W'(r_q) * ADDR_W'(WORDS_PER_ROW) + ADDR_W'(c_q);
  assign flr_addr = reg_addr + ADDR_W'(WORDS_PER_ROW);
  assign busy     = state_q != IDLE;
  assign done     = done_q;
  // strobes drop as soon as reset is seen so an aborted sweep never writes on the reset edge
  assign rd_st    = state_q == RD_REG || state_q == RD_FLR;
  assign wr_st    = state_q == WR_REG || state_q == WR_FLR;
  assign mem_rd   = !reset && rd_st;
  assign mem_wr   = !reset && wr_st;
  assign upd_docalc = !reset && wr_st;
  assign mem_addr = (state_q == RD_FLR || state_q == WR_FLR) ? flr_addr : busy ? reg_addr : '0;
  assign mem_wdata = state_q == WR_REG ? upd_new_region : state_q == WR_FLR ? upd_new_floor : '0;
  assign upd_screenbegin = busy && c_q == '0;
  assign upd_screenend   = busy && c_last;
  assign upd_region = region_q;
  assign upd_floor  = floor_q;
endmodule

// File: tb/tb_sand_sweep.sv
// tb_sand_sweep: checks sand_sweep traces on a 2x3 screen and random sweeps on a 1x5 screen against a word-level model.
module tb_sand_sweep;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, start_b = 1'b0;
  always #5 clk = ~clk;
  int total = 0, bad = 0;
  logic a_busy, a_done, a_rd, a_wr, a_dc, a_sb, a_se;
  logic [14:0] a_addr;
  logic [31:0] a_wdata, a_rdata, a_reg, a_flr, a_nreg, a_nflr;
  logic b_busy, b_done, b_rd, b_wr, b_dc, b_sb, b_se;
  logic [14:0] b_addr;
  logic [31:0] b_wdata, b_rdata, b_reg, b_flr, b_nreg, b_nflr;
  logic [31:0] ram_a [0:32767];
  logic [31:0] ram_b [0:32767];
  logic [31:0] ea [6];
  logic [31:0] eb [5];
  typedef struct {logic [4:0] f; int addr;} vec_t;
  vec_t tv [20];
  int n, nd, nw;
  logic ok;
  assign a_nreg = a_reg ^ 32'hFFFFFFFF;
  assign a_nflr = a_flr + 32'd1;
  assign b_nreg = b_reg ^ 32'hFFFFFFFF;
  assign b_nflr = b_flr + 32'd1;
  always @(posedge clk) begin
    if (a_rd) a_rdata <= ram_a[a_addr];
    if (a_wr) ram_a[a_addr] <= a_wdata;
    if (b_rd) b_rdata <= ram_b[b_addr];
    if (b_wr) ram_b[b_addr] <= b_wdata;
  end
  sand_sweep #(.WORDS_PER_ROW(2), .ROWS(3), .ADDR_W(15)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(a_busy), .done(a_done),
    .mem_addr(a_addr), .mem_rd(a_rd), .mem_wr(a_wr), .mem_wdata(a_wdata), .mem_rdata(a_rdata),
    .upd_docalc(a_dc), .upd_screenbegin(a_sb), .upd_screenend(a_se),
    .upd_region(a_reg), .upd_floor(a_flr), .upd_new_region(a_nreg), .upd_new_floor(a_nflr));
  sand_sweep #(.WORDS_PER_ROW(1), .ROWS(5), .ADDR_W(15)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(b_busy), .done(b_done),
    .mem_addr(b_addr), .mem_rd(b_rd), .mem_wr(b_wr), .mem_wdata(b_wdata), .mem_rdata(b_rdata),
    .upd_docalc(b_dc), .upd_screenbegin(b_sb), .upd_screenend(b_se),
    .upd_region(b_reg), .upd_floor(b_flr), .upd_new_region(b_nreg), .upd_new_floor(b_nflr));
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  // each word: region = ~region, floor = floor + 1, rows bottom-up, columns left to right
  task automatic model_a;
    for (int r = 1; r >= 0; r--)
      for (int c = 0; c < 2; c++) begin
        ea[r*2+c]     = ~ea[r*2+c];
        ea[(r+1)*2+c] = ea[(r+1)*2+c] + 32'd1;
      end
  endtask
  task automatic cmp_ram_a(input string nm);
    for (int i = 0; i < 6; i++) chk(nm, ram_a[i], ea[i]);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    // flags {rd, wr, screenbegin, screenend, docalc}; addr -1 = not checked
    tv = '{'{5'b10100, 2}, '{5'b10100, 4}, '{5'b00100, -1}, '{5'b01101, 2}, '{5'b01101, 4},
           '{5'b10010, 3}, '{5'b10010, 5}, '{5'b00010, -1}, '{5'b01011, 3}, '{5'b01011, 5},
           '{5'b10100, 0}, '{5'b10100, 2}, '{5'b00100, -1}, '{5'b01101, 0}, '{5'b01101, 2},
           '{5'b10010, 1}, '{5'b10010, 3}, '{5'b00010, -1}, '{5'b01011, 1}, '{5'b01011, 3}};
    reset = 1'b1;
    start = 1'b1;
    start_b = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_flags", 32'({a_busy, a_done, a_rd, a_wr, a_dc, a_sb, a_se}), 0);
    chk("reset_addr", 32'(a_addr), 0);
    chk("reset_wdata", a_wdata, 0);
    chk("reset_region", a_reg, 0);
    chk("reset_floor", a_flr, 0);
    reset = 1'b0;
    start = 1'b0;
    start_b = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("post_reset_idle", 32'({a_busy, a_done, a_rd, a_wr, a_dc, b_busy, b_rd, b_wr}), 0);
    end
    for (int i = 0; i < 6; i++) ram_a[i] = $urandom;
    ram_a[2] = 32'h00000001;
    ram_a[4] = 32'h00000000;
    for (int i = 0; i < 6; i++) ea[i] = ram_a[i];
    model_a();
    start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      chk($sformatf("trace_flags_c%0d", i + 1), 32'({a_rd, a_wr, a_sb, a_se, a_dc}), 32'(tv[i].f));
      if (tv[i].addr >= 0) chk($sformatf("trace_addr_c%0d", i + 1), 32'(a_addr), tv[i].addr);
      chk($sformatf("trace_busy_c%0d", i + 1), 32'(a_busy), 1);
      if (i == 3) chk("wr2_data", a_wdata, 32'hFFFFFFFE);
      if (i == 4) chk("wr4_data", a_wdata, 32'h00000001);
    end
    @(negedge clk);
    chk("done_c21", 32'({a_done, a_busy}), 32'b10);
    @(negedge clk);
    chk("done_one_cycle", 32'(a_done), 0);
    cmp_ram_a("ram_sweep1");
    model_a();
    nd = 0;
    start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 0 || i == 7) start = 1'b0;
      if (i == 6) start = 1'b1;
      if (a_done) nd++;
    end
    chk("repulse_one_done", nd, 1);
    cmp_ram_a("ram_sweep2");
    nd = 0;
    nw = 0;
    start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      if (i == 11) reset = 1'b1;
      if (i == 13) reset = 1'b0;
      if (i >= 11 && a_wr) nw++;
      if (i >= 11 && a_done) nd++;
    end
    chk("abort_no_writes", nw, 0);
    chk("abort_no_done", nd, 0);
    chk("abort_idle", 32'(a_busy), 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_first_rd", 32'({a_rd, a_wr, a_addr}), 32'({1'b1, 1'b0, 15'd2}));
    n = 0;
    while (!a_done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("restart_done_cycle", n, 20);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_on_done_ignored", 32'(a_busy), 0);
    @(negedge clk);
    chk("still_idle", 32'({a_busy, a_rd}), 0);
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 5; i++) begin
        ram_b[i] = $urandom;
        eb[i] = ram_b[i];
      end
      for (int r = 3; r >= 0; r--) begin
        eb[r]   = ~eb[r];
        eb[r+1] = eb[r+1] + 32'd1;
      end
      start_b = 1'b1;
      n = 0;
      ok = 1'b1;
      while (n < 100) begin
        @(negedge clk);
        n++;
        if (b_done) break;
        if (!(b_busy && b_sb && b_se) || (b_rd && b_wr)) ok = 1'b0;
        start_b = 1'($urandom_range(0, 1));
      end
      start_b = 1'b0;
      chk("rand_done_cycle", n, 21);
      chk("rand_edges_strobes", 32'(ok), 1);
      for (int i = 0; i < 5; i++) chk($sformatf("rand_ram%0d", i), ram_b[i], eb[i]);
      @(negedge clk);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
